// File: rtl/ws2812_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ws2812_pkg                                                     |
// | Brief   : Shared types and default 50 MHz timing for the WS2812 chain.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    localparam int c_t0h_cyc = 20;
    localparam int c_t1h_cyc = 40;
    localparam int c_bit_cyc = 63;
    localparam int c_rst_cyc = 3000;

    // Green in [23:16], red in [15:8], blue in [7:0]; MSB leaves first.
    typedef logic [23:0] pixel_t;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ws2812_bit_timer                                               |
// | Brief   : Shared bit/latch cycle counter and registered line level.      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ws2812_bit_timer #(
    parameter int T0H_CYC = 20,
    parameter int T1H_CYC = 40,
    parameter int BIT_CYC = 63,
    parameter int RST_CYC = 3000,
    parameter int CNT_W   = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_send_nxt,
    input  logic i_bit_nxt,
    output logic o_dout,
    output logic o_bit_end,
    output logic o_latch_end
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_high_len;
    logic             r_dout;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign w_high_len = i_bit_nxt ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);

    // The line level is computed from next-cycle count and bit so the
    // registered output lines up with the cycle that count describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_dout <= i_send_nxt && (w_cnt_nxt < w_high_len);
        end
    end

    assign o_dout      = r_dout;
    assign o_bit_end   = (r_cnt == CNT_W'(BIT_CYC - 1));
    assign o_latch_end = (r_cnt == CNT_W'(RST_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/ws2812_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ws2812_tx                                                      |
// | Brief   : GRB pixel stream to WS2812 NRZ serializer with frame latch.    |
// |           Define WS2812_TX_UNDERRUN_EN to build the underrun detector.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int T0H_CYC  = c_t0h_cyc,
    parameter int T1H_CYC  = c_t1h_cyc,
    parameter int BIT_CYC  = c_bit_cyc,
    parameter int RST_CYC  = c_rst_cyc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        dout,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int CNT_W = $clog2(f_max(BIT_CYC, RST_CYC));
    localparam int PIX_W = $clog2(NUM_LEDS + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    pixel_t           r_shift;
    pixel_t           w_shift_nxt;
    logic [4:0]       r_bit_idx;
    logic [4:0]       w_bit_idx_nxt;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [PIX_W-1:0] w_pix_cnt_nxt;
    logic [PIX_W-1:0] w_pix_cnt_inc;
    logic             r_frame_done;
    logic             w_done_nxt;
    logic             w_clr;
    logic             w_inc;
    logic             w_bit_end;
    logic             w_latch_end;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_pix_cnt_nxt = r_pix_cnt;
        w_pix_cnt_inc = r_pix_cnt + PIX_W'(1);
        w_done_nxt    = 1'b0;
        w_clr         = 1'b0;
        w_inc         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_FETCH;
                    w_pix_cnt_nxt = '0;
                    w_clr         = 1'b1;
                end
            end
            ST_FETCH: begin
                if (pix_valid) begin
                    w_state_nxt   = ST_SEND;
                    w_shift_nxt   = pix_data;
                    w_bit_idx_nxt = 5'd23;
                    w_clr         = 1'b1;
                end
            end
            ST_SEND: begin
                w_inc = 1'b1;
                if (w_bit_end) begin
                    w_clr = 1'b1;
                    if (r_bit_idx != 5'd0) begin
                        w_shift_nxt   = {r_shift[22:0], 1'b0};
                        w_bit_idx_nxt = r_bit_idx - 5'd1;
                    end else begin
                        w_pix_cnt_nxt = w_pix_cnt_inc;
                        w_state_nxt   = (w_pix_cnt_inc < PIX_W'(NUM_LEDS)) ? ST_FETCH : ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                w_inc = 1'b1;
                if (w_latch_end) begin
                    w_clr       = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_idx    <= 5'd0;
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_pix_cnt    <= w_pix_cnt_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    ws2812_bit_timer #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC),
        .RST_CYC (RST_CYC),
        .CNT_W   (CNT_W)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_inc       (w_inc),
        .i_send_nxt  (w_state_nxt == ST_SEND),
        .i_bit_nxt   (w_shift_nxt[23]),
        .o_dout      (dout),
        .o_bit_end   (w_bit_end),
        .o_latch_end (w_latch_end)
    );

    assign pix_ready  = (r_state == ST_FETCH);
    // frame_done is issued from IDLE, so it must extend busy by one cycle.
    assign busy       = (r_state != ST_IDLE) || r_frame_done;
    assign frame_done = r_frame_done;

`ifdef WS2812_TX_UNDERRUN_EN
    logic r_underrun;

    // Any stalled FETCH cycle implies valid was low on entry to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_underrun <= 1'b0;
        end else if ((r_state == ST_FETCH) && !pix_valid && (r_pix_cnt != '0)) begin
            r_underrun <= 1'b1;
        end
    end

    assign underrun = r_underrun;
`else
    assign underrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ws2812_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ws2812_tx                                                   |
// | Brief   : Self-checking bench: per-cycle expected-output scoreboard.     |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ws2812_tx;

    localparam int NUM_LEDS = 3;
    localparam int T0H      = 20;
    localparam int T1H      = 40;
    localparam int BITC     = 63;
    localparam int RSTC     = 3000;
`ifdef WS2812_TX_UNDERRUN_EN
    localparam bit UNDERRUN_ON = 1'b1;
`else
    localparam bit UNDERRUN_ON = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        start     = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data  = '0;
    logic        pix_ready;
    logic        dout;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    // Expected {busy, pix_ready, dout, frame_done, underrun} per cycle.
    logic [4:0] exp_q[$];
    logic       u_model = 1'b0;

    ws2812_tx #(
        .NUM_LEDS (NUM_LEDS),
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .BIT_CYC  (BITC),
        .RST_CYC  (RSTC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic push_n(input int n, input logic [3:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back({v, u_model});
    endtask

    // Cycle 0 is the start cycle; the frame ends on the frame_done cycle.
    task automatic run_frame(input string name, input logic [23:0] p0, input logic [23:0] p1,
                             input logic [23:0] p2, input int s0, input int s1, input int s2,
                             input int mid_start);
        logic [23:0] px[3];
        int          st[3];
        int          j = 0, stall_rem, hs = 0, mism = 0, done_at = -1, cyc = 0, bad_cyc = -1;
        int          exp_done, h;
        logic [4:0]  e, obs, bad_e, bad_o;
        px = '{p0, p1, p2};
        st = '{s0, s1, s2};
        exp_q.delete();
        push_n(1, 4'b0000);
        u_model = 1'b0;
        for (int p = 0; p < NUM_LEDS; p++) begin
            for (int c = 0; c <= st[p]; c++) begin
                exp_q.push_back({4'b1100, u_model});
                if (c == 0 && p > 0 && st[p] > 0 && UNDERRUN_ON) u_model = 1'b1;
            end
            for (int b = 23; b >= 0; b--) begin
                h = px[p][b] ? T1H : T0H;
                push_n(h, 4'b1010);
                push_n(BITC - h, 4'b1000);
            end
        end
        push_n(RSTC, 4'b1000);
        push_n(1, 4'b1001);
        exp_done = NUM_LEDS * (24 * BITC + 1) + s0 + s1 + s2 + RSTC + 1;

        stall_rem = st[0];
        bad_e = '0;
        bad_o = '0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {busy, pix_ready, dout, frame_done, underrun};
            if (obs !== e) begin
                mism++;
                if (bad_cyc < 0) begin
                    bad_cyc = cyc;
                    bad_e   = e;
                    bad_o   = obs;
                end
            end
            if (frame_done === 1'b1 && done_at < 0) done_at = cyc;
            start = (cyc == 0) || (cyc == mid_start);
            if (j < NUM_LEDS) begin
                pix_data = px[j];
                if (pix_ready === 1'b1) begin
                    if (stall_rem > 0) begin
                        pix_valid = 1'b0;
                        stall_rem--;
                    end else begin
                        pix_valid = 1'b1;
                        hs++;
                        j++;
                        if (j < NUM_LEDS) stall_rem = st[j];
                    end
                end else begin
                    pix_valid = (stall_rem == 0);
                end
            end else begin
                pix_valid = 1'b0;
            end
            cyc++;
        end

        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL %s waveform: %0d cycles differ, first at cycle %0d got {busy,ready,dout,done,underrun}=%b required %b",
                     name, mism, bad_cyc, bad_o, bad_e);
        end
        checks++;
        if (hs !== NUM_LEDS) begin
            errors++;
            $display("FAIL %s handshakes: got %0d required %0d", name, hs, NUM_LEDS);
        end
        checks++;
        if (done_at !== exp_done) begin
            errors++;
            $display("FAIL %s frame_done cycle: got %0d required %0d", name, done_at, exp_done);
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, pix_ready, dout, frame_done, underrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset outputs: got %b required 00000",
                     {busy, pix_ready, dout, frame_done, underrun});
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({busy, pix_ready, dout, frame_done, underrun} !== 5'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle outputs: %0d of 100 cycles nonzero, required 0", bad);
        end
        u_model = 1'b0;
    endtask

    task automatic test_basic_frame;
        run_frame("basic", 24'h800001, 24'h00FF00, 24'hA5A5A5, 0, 0, 0, -1);
    endtask

    task automatic test_underrun;
        run_frame("stall", 24'h123456, 24'hFEDCBA, 24'h0F0F0F, 0, 10, 0, 3200);
        checks++;
        if (underrun !== UNDERRUN_ON) begin
            errors++;
            $display("FAIL underrun flag after stall: got %b required %b", underrun, UNDERRUN_ON);
        end
    endtask

    task automatic test_start_ignored;
        run_frame("mid start", 24'hFFFFFF, 24'h000000, 24'h5A5A5A, 4, 0, 0, 2000);
    endtask

    task automatic test_reset_midframe;
        int bad = 0;
        for (int c = 0; c <= 700; c++) begin
            @(negedge clk);
            start     = (c == 0);
            pix_valid = (c <= 1);
            pix_data  = 24'hFFF000;
            if (c == 700) begin
                checks++;
                if (dout !== 1'b1) begin
                    errors++;
                    $display("FAIL dout in bit 12 high phase: got %b required 1", dout);
                end
                rst = 1'b1;
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, pix_ready, dout, frame_done, underrun} !== 5'b0) begin
            errors++;
            $display("FAIL outputs after mid-frame reset: got %b required 00000",
                     {busy, pix_ready, dout, frame_done, underrun});
        end
        rst       = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({busy, pix_ready, dout, frame_done, underrun} !== 5'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle after mid-frame reset: %0d cycles nonzero, required 0", bad);
        end
        u_model = 1'b0;
        run_frame("after reset", 24'hC3C3C3, 24'h00000F, 24'hF00000, 0, 0, 0, -1);
    endtask

    task automatic test_back_to_back;
        run_frame("b2b first", 24'h81FF18, 24'h7E0042, 24'h123123, 0, 0, 0, -1);
        run_frame("b2b second", 24'h81FF18, 24'h7E0042, 24'h123123, 0, 0, 0, -1);
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_underrun;
        test_start_ignored;
        test_reset_midframe;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
